// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory port, with a BUSY timeout.
// Build option: define ARBITER_ROUND_ROBIN_EN for alternating tie-breaks instead of fixed data priority.
module memory_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iAck,
  output logic [31:0] iRdata,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        dAck,
  output logic [31:0] dRdata,
  output logic        err,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memReady
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic       owner_data;
  logic [7:0] count;
  logic       grant_data;

`ifdef ARBITER_ROUND_ROBIN_EN
  // favor_instr remembers which side should win the next tie
  logic       favor_instr;
  assign grant_data = dReq && (!iReq || !favor_instr);
`else
  assign grant_data = dReq;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_data <= 1'b1;
      count      <= '0;
      iAck       <= 1'b0;
      dAck       <= 1'b0;
      err        <= 1'b0;
      iRdata     <= '0;
      dRdata     <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      favor_instr <= 1'b1;
`endif
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (iReq || dReq) begin
            owner_data <= grant_data;
            memReq     <= 1'b1;
            memWe      <= grant_data && dWe;
            memAddr    <= grant_data ? dAddr : iAddr;
            memWdata   <= grant_data ? dWdata : '0;
            count      <= '0;
            state      <= BUSY;
`ifdef ARBITER_ROUND_ROBIN_EN
            favor_instr <= grant_data;
`endif
          end
        end
        BUSY: begin
          // Ack and err are registered here so they appear exactly in the DONE cycle
          if (memReady || (count == 8'(TIMEOUT - 1))) begin
            if (owner_data) begin
              dRdata <= (memReady && !memWe) ? memRdata : '0;
              dAck   <= 1'b1;
            end else begin
              iRdata <= memReady ? memRdata : '0;
              iAck   <= 1'b1;
            end
            err    <= !memReady;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            state  <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requesters push expected responses, a monitor checks grants and acks.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        iReq = 1'b0;
  logic [31:0] iAddr = '0;
  logic        iAck;
  logic [31:0] iRdata;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic        dAck;
  logic [31:0] dRdata;
  logic        err;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;
  logic        memReady = 1'b0;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dAck(dAck), .dRdata(dRdata),
    .err(err), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          busy;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t i_exp[$];
  exp_t d_exp[$];
  logic [31:0] mem_data [logic [31:0]];
  int          mem_delay [logic [31:0]];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory answers after 'delay' silent BUSY cycles; a delay of TO or more can never be answered in time
  function automatic exp_t model(input logic we, input logic [31:0] data, input int delay);
    exp_t e;
    if (delay >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.busy = TO;
    end else begin
      e.rdata = we ? 32'h0 : data; e.err = 1'b0; e.busy = delay + 1;
    end
    return e;
  endfunction

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
    int n;
    @(negedge clock);
    mem_data[addr] = data;
    mem_delay[addr] = delay;
    i_exp.push_back(model(1'b0, data, delay));
    iAddr = addr;
    iReq = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!iAck && n < 40);
    check_output("fetch_ack_wait", {31'h0, iAck}, 32'h1);
    iReq = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] data, input int delay);
    int n;
    @(negedge clock);
    mem_data[addr] = data;
    mem_delay[addr] = delay;
    d_exp.push_back(model(we, data, delay));
    dWe = we;
    dAddr = addr;
    dWdata = wdata;
    dReq = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!dAck && n < 40);
    check_output("data_ack_wait", {31'h0, dAck}, 32'h1);
    dReq = 1'b0;
  endtask

  // Memory responder; memReady outside BUSY is random noise the arbiter must ignore
  int busy_seen = 0;
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      memReady = 1'b0;
      busy_seen = 0;
    end else if (memReq) begin
      memReady = (busy_seen == (mem_delay.exists(memAddr) ? mem_delay[memAddr] : 0));
      memRdata = (memReady && mem_data.exists(memAddr)) ? mem_data[memAddr] : $urandom();
      busy_seen++;
    end else begin
      busy_seen = 0;
      memReady = 1'($urandom_range(0, 1));
      memRdata = $urandom();
    end
  end

  logic        prev_req;
  logic        last_data;
  logic        g_data;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] last_i;
  logic [31:0] last_d;
  int          busy_cnt;

  // Monitor: predicts each grant from the pending requests and pops the scoreboard on every ack
  initial forever begin
    @(posedge clock);
    #1;
    if (!resetn) begin
      prev_req = 1'b0; busy_cnt = 0; last_i = '0; last_d = '0; last_data = 1'b1;
      i_exp.delete(); d_exp.delete();
      continue;
    end
    if (memReq && !prev_req) begin
      check_output("grant_has_request", {31'h0, iReq || dReq}, 32'h1);
      if (iReq && dReq) begin
`ifdef ARBITER_ROUND_ROBIN_EN
        g_data = !last_data;
`else
        g_data = 1'b1;
`endif
      end else begin
        g_data = dReq;
      end
      last_data = g_data;
      g_addr = g_data ? dAddr : iAddr;
      g_we = g_data ? dWe : 1'b0;
      check_output("grant_addr", memAddr, g_addr);
      check_output("grant_we", {31'h0, memWe}, {31'h0, g_we});
      if (g_data) check_output("grant_wdata", memWdata, dWdata);
      busy_cnt = 1;
    end else if (memReq) begin
      busy_cnt++;
      check_output("busy_addr_stable", memAddr, g_addr);
      check_output("busy_we_stable", {31'h0, memWe}, {31'h0, g_we});
    end
    if (iAck || dAck || (prev_req && !memReq)) begin
      exp_t e;
      check_output("ack_at_busy_end", {31'h0, prev_req && !memReq}, 32'h1);
      check_output("ack_single", {30'h0, iAck, dAck}, g_data ? 32'h1 : 32'h2);
      if (iAck && i_exp.size() > 0) begin
        e = i_exp.pop_front();
        check_output("fetch_rdata", iRdata, e.rdata);
        check_output("fetch_err", {31'h0, err}, {31'h0, e.err});
        check_output("fetch_busy_cycles", busy_cnt, e.busy);
      end else if (dAck && d_exp.size() > 0) begin
        e = d_exp.pop_front();
        check_output("data_rdata", dRdata, e.rdata);
        check_output("data_err", {31'h0, err}, {31'h0, e.err});
        check_output("data_busy_cycles", busy_cnt, e.busy);
      end else begin
        check_output("ack_expected", {31'h0, iAck || dAck}, 32'h0);
      end
      last_i = iRdata;
      last_d = dRdata;
    end else begin
      check_output("idle_err", {31'h0, err}, 32'h0);
      check_output("iRdata_hold", iRdata, last_i);
      check_output("dRdata_hold", dRdata, last_d);
    end
    prev_req = memReq;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_output("reset_memReq", {31'h0, memReq}, 32'h0);
    check_output("reset_acks", {30'h0, iAck, dAck}, 32'h0);
    check_output("reset_err", {31'h0, err}, 32'h0);
    check_output("reset_memAddr", memAddr, 32'h0);
    resetn = 1'b1;

    do_fetch(32'h0000_0010, 32'h00A0_0093, 0);
    do_data(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1357_9BDF, 3);
    do_data(1'b0, 32'h0000_3000, 32'h0, 32'h1234_5678, 9);
    do_data(1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, TO - 1);

    for (int t = 0; t < 2; t++) begin
      fork
        do_fetch(32'h0000_0100 + 32'(t * 8), 32'hA000_0000 + 32'(t), 0);
        do_data(1'b0, 32'h8000_0104 + 32'(t * 8), 32'h0, 32'hB000_0000 + 32'(t), 0);
      join
    end

    fork
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        a = $urandom() & 32'h7FFF_FFFC;
        do_fetch(a, $urandom(), $urandom_range(0, TO + 1));
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        a = $urandom() | 32'h8000_0000;
        do_data(1'($urandom_range(0, 1)), a, $urandom(), $urandom(), $urandom_range(0, TO + 1));
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    join

    // Reset in the middle of a fetch: outputs clear at once and the held request is served afresh
    @(negedge clock);
    mem_data[32'h40] = 32'h7777_8888;
    mem_delay[32'h40] = 7;
    iAddr = 32'h40;
    iReq = 1'b1;
    repeat (2) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_output("async_reset_memReq", {31'h0, memReq}, 32'h0);
    check_output("async_reset_memAddr", memAddr, 32'h0);
    check_output("async_reset_acks", {29'h0, iAck, dAck, err}, 32'h0);
    check_output("async_reset_iRdata", iRdata, 32'h0);
    check_output("async_reset_dRdata", dRdata, 32'h0);
    repeat (2) @(negedge clock);
    mem_delay[32'h40] = 1;
    i_exp.push_back(model(1'b0, 32'h7777_8888, 1));
    resetn = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clock); n++; end while (!iAck && n < 40);
      check_output("post_reset_ack_wait", {31'h0, iAck}, 32'h1);
    end
    iReq = 1'b0;
    repeat (4) @(negedge clock);
    check_output("fetch_queue_empty", i_exp.size(), 32'h0);
    check_output("data_queue_empty", d_exp.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
